// File: rtl/config_pkg.sv
// Shared configuration for the peripheral slice: clocking, UART and FIFO
// constants, plus the UART receiver state type.
package config_pkg;

  // System clock and default UART line rate.
  localparam int unsigned ClkFreqHz       = 100_000_000;
  localparam int unsigned UartBaudDefault = 115_200;

  // UART framing and FIFO sizing.
  localparam int unsigned UartDataW     = 8;
  localparam int unsigned UartFifoDepth = 16;

  // Receiver defaults: bit period in clocks (100 MHz / 115200 = 868).
  localparam int unsigned UartRxDefaultClkPerBit = ClkFreqHz / UartBaudDefault;
  localparam int unsigned UartRxCntW             = 16;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/sync_n.sv
// Parameterised synchroniser flop chain with a configurable reset value.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset (chain forced to ResetVal)
//   i_d     - asynchronous input
//   o_q     - synchronised output (last flop of the chain)
module sync_n #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_chain;

  // Shift the input down the chain, one flop per clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {Stages{ResetVal}};
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < Stages; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a single-entry output register,
// consumer handshake, per-byte interrupt pulse and sticky error flags.
// Ports:
//   clk_i       - clock (rising edge)
//   reset_i     - asynchronous active-low reset
//   prescaler   - bit period in clocks; 0 selects ClkPerBit
//   rx          - asynchronous serial line, idle high
//   data_o      - last received byte
//   valid_o     - data_o holds an unconsumed byte
//   ack_i       - consumer accepts data_o
//   irq_o       - one-cycle pulse per byte loaded into data_o
//   frame_err_o - sticky, bad stop bit seen
//   overrun_o   - sticky, a completed byte was dropped
//   clear_i     - clears both sticky flags (a coincident set wins)
module uart_rx
  import config_pkg::*;
#(
  parameter int unsigned ClkPerBit  = UartRxDefaultClkPerBit,
  parameter int unsigned SyncStages = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [UartRxCntW-1:0] prescaler,
  input  logic                  rx,
  output logic [UartDataW-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ack_i,
  output logic                  irq_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  input  logic                  clear_i
);

  uart_rx_state_t        r_state, w_state_nxt;
  logic [UartRxCntW-1:0] r_cnt, w_cnt_nxt;
  logic [UartRxCntW-1:0] r_period, w_period_nxt;
  logic [2:0]            r_idx, w_idx_nxt;
  logic [UartDataW-1:0]  r_shift, w_shift_nxt;
  logic [UartDataW-1:0]  r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_irq, w_irq_nxt;
  logic                  r_ferr, w_ferr_nxt;
  logic                  r_ovr, w_ovr_nxt;
  logic                  r_rxs_d;

  logic                  w_rxs;
  logic [UartRxCntW-1:0] w_p_sel;
  logic                  w_cnt_zero;
  logic                  w_byte_ok;
  logic                  w_stop_bad;
  logic                  w_ovr_set;

  // Line synchroniser; idles high so reset does not look like a start edge.
  sync_n #(
    .Stages  (SyncStages),
    .ResetVal(1'b1)
  ) u_sync (
    .i_clk  (clk_i),
    .i_rst_n(reset_i),
    .i_d    (rx),
    .o_q    (w_rxs)
  );

  assign w_p_sel    = (prescaler != '0) ? prescaler : UartRxCntW'(ClkPerBit);
  assign w_cnt_zero = (r_cnt == '0);

  // Next-state, datapath and output-register logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    w_irq_nxt    = 1'b0;
    w_byte_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    w_ovr_set    = 1'b0;

    case (r_state)
      RX_IDLE: begin
        // Period is captured only here, so mid-frame changes are ignored.
        if (r_rxs_d && !w_rxs) begin
          w_period_nxt = w_p_sel;
          w_cnt_nxt    = (w_p_sel >> 1) - UartRxCntW'(1);
          w_state_nxt  = RX_START;
        end
      end
      RX_START: begin
        if (w_cnt_zero) begin
          if (!w_rxs) begin
            w_cnt_nxt   = r_period - UartRxCntW'(1);
            w_idx_nxt   = 3'd0;
            w_state_nxt = RX_DATA;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - UartRxCntW'(1);
        end
      end
      RX_DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt[r_idx] = w_rxs;
          w_cnt_nxt          = r_period - UartRxCntW'(1);
          if (r_idx == 3'd7) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - UartRxCntW'(1);
        end
      end
      RX_STOP: begin
        if (w_cnt_zero) begin
          if (w_rxs) begin
            w_byte_ok   = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt - UartRxCntW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        // Hold off until the line recovers so a break cannot retrigger.
        if (w_rxs) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase

    // A completing byte is dropped only if the old one is still unconsumed.
    if (w_byte_ok && r_valid && !ack_i) begin
      w_ovr_set = 1'b1;
    end else if (w_byte_ok) begin
      w_data_nxt  = r_shift;
      w_valid_nxt = 1'b1;
      w_irq_nxt   = 1'b1;
    end else if (ack_i && r_valid) begin
      w_valid_nxt = 1'b0;
    end

    w_ferr_nxt = w_stop_bad | (r_ferr & ~clear_i);
    w_ovr_nxt  = w_ovr_set  | (r_ovr  & ~clear_i);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_irq    <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_rxs_d  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_irq    <= w_irq_nxt;
      r_ferr   <= w_ferr_nxt;
      r_ovr    <= w_ovr_nxt;
      r_rxs_d  <= w_rxs;
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign irq_o       = r_irq;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level driver, event-based model of
// the output register and flags, per-cycle compare, plus literal checks.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Ss  = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [15:0] prescaler = 16'd0;
  logic        rx        = 1'b1;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ack       = 1'b0;
  logic        irq_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        clear     = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .ClkPerBit (Cpb),
    .SyncStages(Ss)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst_n),
    .prescaler  (prescaler),
    .rx         (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ack_i      (ack),
    .irq_o      (irq_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .clear_i    (clear)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  b;
    bit          ok;
  } ev_t;

  ev_t         evq[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int unsigned irq_cnt = 0;
  int unsigned last_irq_cyc = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_irq = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned eff_p(input logic [15:0] ps);
    return (ps == 16'd0) ? Cpb : 32'(ps);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one frame. abort_k >= 0 stops after that many bit-clocks with no
  // byte expected; ack_done raises ack exactly on the completion cycle.
  task automatic send(input logic [7:0] b, input bit stop, input int hold_low,
                      input bit ack_done, input bit scramble, input int abort_k);
    int unsigned p    = eff_p(prescaler);
    int unsigned t0   = cyc;
    int unsigned done = t0 + Ss + 1 + p / 2 + 9 * p;
    logic [15:0] ps_save = prescaler;
    logic [9:0]  fr = {stop, b, 1'b0};
    ev_t         e;
    if (abort_k < 0) begin
      e.cyc = done; e.b = b; e.ok = stop;
      evq.push_back(e);
    end
    for (int k = 0; k < int'(10 * p); k++) begin
      if (abort_k >= 0 && k == abort_k) return;
      rx = fr[4'(k / int'(p))];
      if (ack_done) ack = (cyc == done - 1);
      if (scramble && k == int'(p)) prescaler = 16'($urandom_range(4, 60));
      step();
    end
    ack = 1'b0;
    prescaler = ps_save;
    rx = 1'b0;
    repeat (hold_low) step();
    rx = 1'b1;
    repeat (p + 4) step();
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0; step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0; step();
  endtask

  initial begin
    int unsigned t0;
    int unsigned i0;

    fork
      // Model: apply each completion event by the handshake/flag rules.
      begin : model
        forever begin
          bit   loaded, set_o, set_f, ack_now;
          ev_t  e;
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            m_data = 8'h00; m_valid = 1'b0; m_irq = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
            evq.delete();
          end else begin
            cyc++;
            m_irq = 1'b0; loaded = 1'b0; set_o = 1'b0; set_f = 1'b0;
            ack_now = ack && m_valid;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
              e = evq.pop_front();
              if (!e.ok) set_f = 1'b1;
              else if (m_valid && !ack) set_o = 1'b1;
              else begin
                m_data = e.b; m_valid = 1'b1; m_irq = 1'b1; loaded = 1'b1;
              end
            end
            if (!loaded && ack_now) m_valid = 1'b0;
            m_ovr = set_o | (m_ovr & !clear);
            m_fe  = set_f | (m_fe & !clear);
          end
        end
      end
      // Compare every cycle, away from the active edge.
      begin : cmp
        forever begin
          @(negedge clk);
          if (rst_n) begin
            chk("data_o", 32'(data_o), 32'(m_data));
            chk("valid_o", 32'(valid_o), 32'(m_valid));
            chk("irq_o", 32'(irq_o), 32'(m_irq));
            chk("frame_err_o", 32'(frame_err_o), 32'(m_fe));
            chk("overrun_o", 32'(overrun_o), 32'(m_ovr));
            if (irq_o) begin
              irq_cnt++;
              last_irq_cyc = cyc;
            end
          end
        end
      end
    join_none

    repeat (3) step();
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_flags", 32'({irq_o, frame_err_o, overrun_o}), 32'h0);
    rst_n = 1'b1;
    repeat (5) step();

    // Basic byte and latency.
    t0 = cyc; i0 = irq_cnt;
    send(8'hA5, 1'b1, 0, 1'b0, 1'b0, -1);
    chk("a5_data", 32'(data_o), 32'hA5);
    chk("a5_valid", 32'(valid_o), 32'h1);
    chk("a5_irqs", irq_cnt - i0, 32'd1);
    chk("a5_latency", last_irq_cyc - t0, 32'd155);
    chk("a5_flags", 32'({frame_err_o, overrun_o}), 32'h0);
    pulse_ack();
    chk("ack_clears", 32'(valid_o), 32'h0);
    pulse_ack();
    chk("ack_ignored", 32'(valid_o), 32'h0);

    // Start glitch.
    i0 = irq_cnt;
    rx = 1'b0; repeat (4) step();
    rx = 1'b1; repeat (40) step();
    chk("glitch_valid", 32'(valid_o), 32'h0);
    chk("glitch_irqs", irq_cnt - i0, 32'd0);

    // Framing error followed by a held break, then recovery.
    i0 = irq_cnt;
    send(8'h3C, 1'b0, 100, 1'b0, 1'b0, -1);
    chk("fe_set", 32'(frame_err_o), 32'h1);
    chk("fe_valid", 32'(valid_o), 32'h0);
    chk("fe_irqs", irq_cnt - i0, 32'd0);
    send(8'h01, 1'b1, 0, 1'b0, 1'b0, -1);
    chk("after_break", 32'(data_o), 32'h01);
    pulse_clear();
    chk("fe_clear", 32'(frame_err_o), 32'h0);
    pulse_ack();

    // Overrun.
    i0 = irq_cnt;
    send(8'h11, 1'b1, 0, 1'b0, 1'b0, -1);
    send(8'h22, 1'b1, 0, 1'b0, 1'b0, -1);
    chk("ovr_data", 32'(data_o), 32'h11);
    chk("ovr_set", 32'(overrun_o), 32'h1);
    chk("ovr_irqs", irq_cnt - i0, 32'd1);
    pulse_clear();
    chk("ovr_clear", 32'(overrun_o), 32'h0);
    pulse_ack();

    // Ack on the completion cycle of the second byte.
    i0 = irq_cnt;
    send(8'h11, 1'b1, 0, 1'b0, 1'b0, -1);
    send(8'h22, 1'b1, 0, 1'b1, 1'b0, -1);
    chk("ackdone_data", 32'(data_o), 32'h22);
    chk("ackdone_valid", 32'(valid_o), 32'h1);
    chk("ackdone_ovr", 32'(overrun_o), 32'h0);
    chk("ackdone_irqs", irq_cnt - i0, 32'd2);

    // Reset during data bit 4 of 0xFF.
    send(8'hFF, 1'b1, 0, 1'b0, 1'b0, int'(5 * Cpb + Cpb / 2));
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(data_o), 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_flags", 32'({irq_o, frame_err_o, overrun_o}), 32'h0);
    rx = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    send(8'h5A, 1'b1, 0, 1'b0, 1'b0, -1);
    chk("postrst_data", 32'(data_o), 32'h5A);
    pulse_ack();

    // Half baud via prescaler.
    prescaler = 16'd32;
    t0 = cyc; i0 = irq_cnt;
    send(8'hC3, 1'b1, 0, 1'b0, 1'b0, -1);
    chk("ps32_data", 32'(data_o), 32'hC3);
    chk("ps32_irqs", irq_cnt - i0, 32'd1);
    chk("ps32_latency", last_irq_cyc - t0, 32'd307);
    prescaler = 16'd0;
    pulse_ack();

    // Randomised frames, periods, stop bits, acks and clears.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) prescaler = 16'd0;
      else prescaler = 16'($urandom_range(6, 40));
      send(8'($urandom), ($urandom_range(0, 4) != 0), 0,
           ($urandom_range(0, 3) == 0), 1'b1, -1);
      if ($urandom_range(0, 1) == 0) pulse_ack();
      if ($urandom_range(0, 3) == 0) pulse_clear();
    end
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
